// File: rtl/hamming_secded_decoder.sv
// SECDED decoder for 16-bit Hamming codewords carrying 11 data bits.
// Stage 1 registers the codeword with its syndrome and overall parity.
// Stage 2 classifies the error, corrects single-bit errors and registers the result.
// Saturating counters track corrected and uncorrectable words seen at the output handshake.
module hamming_secded_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16:1]      in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic             out_single,
    output logic             out_double,
    output logic [3:0]       out_syndrome,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_single,
    output logic [CNT_W-1:0] cnt_double
);

    // Syndrome bit k is the parity of every position whose index has bit k set.
    function automatic logic [3:0] calc_syndrome(input logic [16:1] c);
        logic [3:0] s;
        s[0] = c[1] ^ c[3] ^ c[5]  ^ c[7]  ^ c[9]  ^ c[11] ^ c[13] ^ c[15];
        s[1] = c[2] ^ c[3] ^ c[6]  ^ c[7]  ^ c[10] ^ c[11] ^ c[14] ^ c[15];
        s[2] = c[4] ^ c[5] ^ c[6]  ^ c[7]  ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        s[3] = c[8] ^ c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
        return s;
    endfunction

    // Flip the codeword bit addressed by a nonzero syndrome.
    function automatic logic [15:1] flip_bit(input logic [15:1] c, input logic [3:0] s);
        logic [15:1] r;
        r = c;
        for (int i = 1; i < 16; i++) begin
            if (int'(s) == i) begin
                r[i] = ~r[i];
            end
        end
        return r;
    endfunction

    // Data bits live in the non-power-of-two positions.
    function automatic logic [10:0] extract_data(input logic [15:1] c);
        return {c[15], c[14], c[13], c[12], c[11], c[10], c[9], c[7], c[6], c[5], c[3]};
    endfunction

    // Counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    logic              r_vld_p1;
    logic [15:1]       r_code_p1;
    logic [3:0]        r_syn_p1;
    logic              r_par_p1;

    logic              r_vld_p2;
    logic [10:0]       r_data_p2;
    logic              r_single_p2;
    logic              r_double_p2;
    logic [3:0]        r_syn_p2;

    logic [CNT_W-1:0]  r_cnt_single;
    logic [CNT_W-1:0]  r_cnt_double;

    logic              w_s2_adv;
    logic              w_s1_adv;
    logic              w_accept;
    logic              w_out_hs;
    logic              w_syn_nz;
    logic [15:1]       w_code_fix;
    logic              w_single;
    logic              w_double;

    assign w_s2_adv = !r_vld_p2 || out_ready;
    assign w_s1_adv = !r_vld_p1 || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign w_out_hs = r_vld_p2 && out_ready;

    // ---- stage 1: capture codeword, syndrome and overall parity ----

    // Load a new word whenever stage 1 is free to move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_code_p1 <= '0;
            r_syn_p1  <= '0;
            r_par_p1  <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= in_valid;
            if (w_accept) begin
                r_code_p1 <= in_code[15:1];
                r_syn_p1  <= calc_syndrome(in_code);
                r_par_p1  <= ^in_code;
            end
        end
    end

    // ---- stage 2: classify, correct, extract ----

    // Odd overall parity means one flipped bit; a nonzero syndrome with even parity means two.
    always_comb begin
        w_syn_nz   = (r_syn_p1 != 4'd0);
        w_single   = r_par_p1;
        w_double   = w_syn_nz && !r_par_p1;
        w_code_fix = (w_syn_nz && r_par_p1) ? flip_bit(r_code_p1, r_syn_p1) : r_code_p1;
    end

    // Output register holds its contents while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2    <= 1'b0;
            r_data_p2   <= '0;
            r_single_p2 <= 1'b0;
            r_double_p2 <= 1'b0;
            r_syn_p2    <= '0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2   <= extract_data(w_code_fix);
                r_single_p2 <= w_single;
                r_double_p2 <= w_double;
                r_syn_p2    <= r_syn_p1;
            end
        end
    end

    // ---- status counters on the output handshake ----

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (cnt_clr) begin
            r_cnt_single <= '0;
            r_cnt_double <= '0;
        end else if (w_out_hs) begin
            if (r_single_p2) begin
                r_cnt_single <= sat_inc(r_cnt_single);
            end
            if (r_double_p2) begin
                r_cnt_double <= sat_inc(r_cnt_double);
            end
        end
    end

    assign in_ready     = w_s1_adv;
    assign out_valid    = r_vld_p2;
    assign out_data     = r_data_p2;
    assign out_single   = r_single_p2;
    assign out_double   = r_double_p2;
    assign out_syndrome = r_syn_p2;
    assign cnt_single   = r_cnt_single;
    assign cnt_double   = r_cnt_double;

endmodule

// File: tb/tb_hamming_secded_decoder.sv
// Scoreboard bench for hamming_secded_decoder: the driver pushes the
// reference result of every accepted codeword, a negedge monitor pops
// and compares on each output handshake and tracks the counters.
module tb_hamming_secded_decoder;

    localparam int CW = 4;
    localparam int DPOS [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    typedef struct {
        logic [10:0] d;
        logic        s;
        logic        db;
        logic [3:0]  syn;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [16:1]   in_code;
    logic          out_valid;
    logic          out_ready;
    logic [10:0]   out_data;
    logic          out_single;
    logic          out_double;
    logic [3:0]    out_syndrome;
    logic          cnt_clr;
    logic [CW-1:0] cnt_single;
    logic [CW-1:0] cnt_double;

    exp_t          q[$];
    int            n_chk  = 0;
    int            n_fail = 0;
    logic [CW-1:0] exp_cs = '0;
    logic [CW-1:0] exp_cd = '0;
    logic          have_prev = 1'b0;
    logic [10:0]   prev_d;
    logic          prev_s, prev_db;
    logic [3:0]    prev_syn;
    logic          rnd_done;

    hamming_secded_decoder #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_single(out_single), .out_double(out_double), .out_syndrome(out_syndrome),
        .cnt_clr(cnt_clr), .cnt_single(cnt_single), .cnt_double(cnt_double)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode: the syndrome is the XOR of the indices of all set bits in 1..15.
    function automatic exp_t model(input logic [16:1] c);
        exp_t        e;
        logic [3:0]  syn;
        logic        par;
        logic [16:1] w;
        syn = 4'd0;
        par = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (c[i]) begin
                par = ~par;
                if (i < 16) syn = syn ^ 4'(i);
            end
        end
        w    = c;
        e.s  = 1'b0;
        e.db = 1'b0;
        if (par) begin
            e.s = 1'b1;
            if (syn != 4'd0) w[int'(syn)] = ~w[int'(syn)];
        end else if (syn != 4'd0) begin
            e.db = 1'b1;
        end
        for (int k = 0; k < 11; k++) e.d[k] = w[DPOS[k]];
        e.syn = syn;
        return e;
    endfunction

    function automatic logic [16:1] encode(input logic [10:0] d);
        logic [16:1] c;
        logic [3:0]  syn;
        c   = '0;
        syn = 4'd0;
        for (int k = 0; k < 11; k++) begin
            c[DPOS[k]] = d[k];
            if (d[k]) syn = syn ^ 4'(DPOS[k]);
        end
        c[1]  = syn[0];
        c[2]  = syn[1];
        c[4]  = syn[2];
        c[8]  = syn[3];
        c[16] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [16:1] rand_code();
        logic [16:1] c;
        int          nflip, p1, p2;
        c     = encode(11'($urandom));
        nflip = $urandom_range(0, 2);
        p1    = $urandom_range(1, 16);
        p2    = (p1 % 16) + $urandom_range(1, 15);
        if (p2 > 16) p2 = p2 - 16;
        if (nflip >= 1) c[p1] = ~c[p1];
        if (nflip == 2) c[p2] = ~c[p2];
        return c;
    endfunction

    // Present a word, wait for acceptance, record its expected result.
    task automatic send(input logic [16:1] c);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_code  = c;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 required 1 within 200 cycles");
        end else begin
            q.push_back(model(c));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && guard < 500) begin
            guard++;
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", q.size(), 0);
    endtask

    // Monitor: compare on handshake, check stall stability and counters every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            exp_cs    = '0;
            exp_cd    = '0;
            have_prev = 1'b0;
        end else begin
            chk("cnt_single", cnt_single, exp_cs);
            chk("cnt_double", cnt_double, exp_cd);
            if (have_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_d);
                chk("stall_flags", {out_single, out_double, out_syndrome}, {prev_s, prev_db, prev_syn});
            end
            if (out_valid) begin
                chk("flags_exclusive", out_single & out_double, 0);
            end
            e.s  = 1'b0;
            e.db = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL spurious_output: got data %0h required no output", out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_single", out_single, e.s);
                    chk("out_double", out_double, e.db);
                    chk("out_syndrome", out_syndrome, e.syn);
                end
            end
            if (cnt_clr) begin
                exp_cs = '0;
                exp_cd = '0;
            end else begin
                if (e.s && exp_cs != '1) exp_cs = exp_cs + 1'b1;
                if (e.db && exp_cd != '1) exp_cd = exp_cd + 1'b1;
            end
            have_prev = out_valid && !out_ready;
            prev_d    = out_data;
            prev_s    = out_single;
            prev_db   = out_double;
            prev_syn  = out_syndrome;
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_code   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        rnd_done  = 1'b0;
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {out_data, out_single, out_double, out_syndrome}, 0);
        chk("reset_counters", {cnt_single, cnt_double}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Clean word: latency of two edges from accept to out_valid.
        send(16'h8007);
        in_valid = 1'b0;
        chk("latency_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_valid", out_valid, 1);
        chk("clean_data", out_data, 11'h001);
        chk("clean_flags", {out_single, out_double, out_syndrome}, 6'h00);
        drain();

        // Single, double and position-16 errors.
        send(16'h8017);
        send(16'h8037);
        send(16'h0007);
        drain();
        chk("cnt_single_directed", cnt_single, 2);
        chk("cnt_double_directed", cnt_double, 1);

        // Back-to-back with the consumer stalled for three cycles.
        out_ready = 1'b0;
        send(16'hFFFF);
        send(16'h0000);
        in_code = 16'h8007;
        @(negedge clk);
        chk("in_ready_full", in_ready, 0);
        @(posedge clk);
        #1;
        fork
            send(16'h8007);
            begin
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Saturation of the single-error counter.
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        repeat (16) send(16'h8017);
        drain();
        chk("cnt_single_saturated", cnt_single, 4'hF);

        // Clear in the same cycle as a single-error handshake.
        out_ready = 1'b0;
        send(16'h8017);
        in_valid = 1'b0;
        begin
            int guard;
            guard = 0;
            while (!out_valid && guard < 20) begin
                guard++;
                @(posedge clk);
                #1;
            end
        end
        chk("clr_word_present", out_valid, 1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_priority", cnt_single, 0);
        drain();

        // Randomised traffic with random stalls and occasional clears.
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    send(rand_code());
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    cnt_clr   = ($urandom_range(0, 31) == 0);
                end
                out_ready = 1'b1;
                cnt_clr   = 1'b0;
            end
        join
        drain();

        // Asynchronous reset with both stages occupied.
        send(16'h8037);
        drain();
        out_ready = 1'b0;
        send(16'h8017);
        send(16'h0007);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_outputs", {out_data, out_single, out_double, out_syndrome}, 0);
        chk("midrst_counters", {cnt_single, cnt_double}, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_reset_quiet", out_valid, 0);
        end
        send(16'h8017);
        drain();
        chk("post_reset_cnt", cnt_single, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
